// File: rtl/timepulse_phase_sequencer.sv
// Timepulse/phase sequencer: twelve timepulses per memory cycle, PHASES clocks each,
// with run, halt-at-end-of-MCT, single-MCT step and GOJAM restart.
module timepulse_phase_sequencer #(
  parameter int PHASES = 8
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        RUN,
  input  logic        MSTP,
  input  logic        GOJAM,
  output logic [11:0] TP_n,
  output logic        CT_n,
  output logic        RT_n,
  output logic        TT_n,
  output logic        WT_n,
  output logic        MCT_END,
  output logic        STOPPED
);
  localparam int PW = $clog2(PHASES);
  localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);
  localparam logic [PW-1:0] PH_2    = PW'(2);
  localparam logic [PW-1:0] PH_3    = PW'(3);
  localparam logic [PW-1:0] PH_4    = PW'(4);
  localparam logic [PW-1:0] RT_LAST = PW'(PHASES - 3);
  localparam logic [PW-1:0] WT_LAST = PW'(PHASES - 2);

  typedef enum logic [1:0] {S_STOPPED, S_RUNNING, S_HALTING} state_t;

  state_t         state;
  logic [PW-1:0]  ph;
  logic [3:0]     tp;
  logic           mstp_q;

  logic active, ph_last, mct_end, mstp_rise;

  assign active    = (state != S_STOPPED);
  assign ph_last   = (ph == PH_LAST);
  assign mct_end   = active && ph_last && (tp == 4'd12);
  assign mstp_rise = MSTP && !mstp_q;

  // Strobes decode straight from ph so they move in the same clock as the counter.
  assign CT_n    = !(active && (ph < PH_2));
  assign RT_n    = !(active && (ph >= PH_2) && (ph <= RT_LAST));
  assign TT_n    = !(active && (ph >= PH_3) && (ph <= PH_4));
  assign WT_n    = !(active && (ph >= PH_4) && (ph <= WT_LAST));
  assign MCT_END = mct_end;
  assign STOPPED = !active;

  always_comb begin
    TP_n = '1;
    for (int i = 0; i < 12; i++)
      TP_n[i] = !(tp == 4'(i + 1));
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state  <= S_STOPPED;
      ph     <= '0;
      tp     <= 4'd1;
      mstp_q <= 1'b0;
    end else begin
      mstp_q <= MSTP;
      if (GOJAM && active) begin
        ph <= '0;
        tp <= 4'd1;
      end else if (active) begin
        // The stop clock is also the natural wrap to T01 ph0, so one counter path serves both.
        if (ph_last) begin
          ph <= '0;
          tp <= (tp == 4'd12) ? 4'd1 : tp + 4'd1;
        end else begin
          ph <= ph + 1'b1;
        end
        if (mct_end && (state == S_HALTING) && !RUN) state <= S_STOPPED;
        else                                         state <= RUN ? S_RUNNING : S_HALTING;
      end else begin
        if (RUN)                          state <= S_RUNNING;
        else if (mstp_rise && !GOJAM)     state <= S_HALTING;
      end
    end
  end
endmodule

// File: tb/tb_timepulse_phase_sequencer.sv
// Bench for timepulse_phase_sequencer: PHASES=8 and PHASES=10 instances share stimulus,
// checked each cycle against a position-in-MCT model plus directed literal expectations.
module tb_timepulse_phase_sequencer;
  logic SIM_CLK, SIM_RST, RUN, MSTP, GOJAM;
  logic [11:0] tp8, tp10;
  logic ct8, rt8, tt8, wt8, end8, st8;
  logic ct10, rt10, tt10, wt10, end10, st10;

  int checks = 0;
  int errors = 0;

  timepulse_phase_sequencer #(.PHASES(8)) u8 (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .RUN(RUN), .MSTP(MSTP), .GOJAM(GOJAM),
    .TP_n(tp8), .CT_n(ct8), .RT_n(rt8), .TT_n(tt8), .WT_n(wt8), .MCT_END(end8), .STOPPED(st8));

  timepulse_phase_sequencer #(.PHASES(10)) u10 (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .RUN(RUN), .MSTP(MSTP), .GOJAM(GOJAM),
    .TP_n(tp10), .CT_n(ct10), .RT_n(rt10), .TT_n(tt10), .WT_n(wt10), .MCT_END(end10), .STOPPED(st10));

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance is either idle or at a position 0..12*P-1 within the MCT.
  int  pv [2] = '{8, 10};
  bit  m_act [2];
  bit  m_halt [2];
  int  m_pos [2];
  bit  m_mq;

  function automatic logic [17:0] expv(input int p, input bit act, input int pos);
    logic [11:0] one;
    logic [11:0] tpn;
    int ph;
    one = 12'd1;
    ph  = pos % p;
    tpn = ~(one << (pos / p));
    return {tpn,
            !(act && ph <= 1),
            !(act && ph >= 2 && ph <= p - 3),
            !(act && ph >= 3 && ph <= 4),
            !(act && ph >= 4 && ph <= p - 2),
            (act && pos == 12 * p - 1),
            !act};
  endfunction

  always @(posedge SIM_CLK) begin
    bit rise;
    rise = MSTP && !m_mq;
    m_mq = SIM_RST ? 1'b0 : MSTP;
    for (int k = 0; k < 2; k++) begin
      if (SIM_RST) begin
        m_act[k] = 0; m_halt[k] = 0; m_pos[k] = 0;
      end else if (m_act[k] && GOJAM) begin
        m_pos[k] = 0;
      end else if (!m_act[k]) begin
        if (RUN) begin m_act[k] = 1; m_halt[k] = 0; end
        else if (rise && !GOJAM) begin m_act[k] = 1; m_halt[k] = 1; end
      end else if (m_pos[k] == 12 * pv[k] - 1 && m_halt[k] && !RUN) begin
        m_act[k] = 0; m_pos[k] = 0;
      end else begin
        m_pos[k] = (m_pos[k] + 1) % (12 * pv[k]);
        m_halt[k] = !RUN;
      end
    end
  end

  always @(posedge SIM_CLK) begin
    #1;
    chk("cycle_p8",  {tp8, ct8, rt8, tt8, wt8, end8, st8},         expv(8,  m_act[0], m_pos[0]));
    chk("cycle_p10", {tp10, ct10, rt10, tt10, wt10, end10, st10}, expv(10, m_act[1], m_pos[1]));
  end

  task automatic smp();
    @(posedge SIM_CLK); #1;
  endtask

  initial begin
    int n8, n10, e8, k, r8, w8, t8, c8, r10, w10;
    bit prev_end;
    int q8[$];
    int q10[$];
    SIM_RST = 1; RUN = 1; MSTP = 0; GOJAM = 0;

    // Reset held with RUN high
    repeat (3) smp();
    chk("rst_tp", tp8, 12'hFFE);
    chk("rst_strobes", {ct8, rt8, tt8, wt8}, 4'hF);
    chk("rst_stopped", st8, 1);
    chk("rst_mct_end", end8, 0);
    @(negedge SIM_CLK); RUN = 0;
    @(negedge SIM_CLK); SIM_RST = 0;
    smp();

    // Continuous run
    @(negedge SIM_CLK); RUN = 1;
    r8 = 0; w8 = 0; t8 = 0; c8 = 0; r10 = 0; w10 = 0;
    for (int i = 0; i < 240; i++) begin
      smp();
      if (i == 0) begin
        chk("run_first_ct", ct8, 0);
        chk("run_first_tp", tp8, 12'hFFE);
      end
      if (i < 8)  begin r8 += !rt8; w8 += !wt8; t8 += !tt8; c8 += !ct8; end
      if (i < 10) begin r10 += !rt10; w10 += !wt10; end
      if (end8) begin q8.push_back(i); chk("mct_end_tp", tp8, 12'h7FF); end
      if (end10) q10.push_back(i);
    end
    chk("rt_low_p8", r8, 4);
    chk("wt_low_p8", w8, 3);
    chk("tt_low_p8", t8, 2);
    chk("ct_low_p8", c8, 2);
    chk("rt_low_p10", r10, 6);
    chk("wt_low_p10", w10, 5);
    chk("end_count_p8", q8.size(), 2);
    chk("end_first_p8", (q8.size() > 0) ? q8[0] : -1, 95);
    chk("end_second_p8", (q8.size() > 1) ? q8[1] : -1, 191);
    chk("end_count_p10", q10.size(), 2);
    chk("end_first_p10", (q10.size() > 0) ? q10[0] : -1, 119);

    // GOJAM at T07 ph3
    k = 0;
    while (!(m_pos[0] == 51) && k < 200) begin smp(); k++; end
    chk("gj_reach", k < 200, 1);
    @(negedge SIM_CLK); GOJAM = 1;
    smp();
    chk("gj_ct", ct8, 0);
    chk("gj_tp", tp8, 12'hFFE);
    chk("gj_stopped", st8, 0);
    @(negedge SIM_CLK); GOJAM = 0;

    // Halt: drop RUN during T05 ph3
    k = 0;
    while (!(m_pos[0] == 35) && k < 200) begin smp(); k++; end
    chk("halt_reach", k < 200, 1);
    @(negedge SIM_CLK); RUN = 0;
    n8 = 0; prev_end = 0;
    for (int i = 0; i < 200; i++) begin
      smp();
      if (st8) break;
      n8++;
      prev_end = end8;
    end
    chk("halt_counted", n8, 60);
    chk("halt_prev_end", prev_end, 1);
    chk("halt_tp", tp8, 12'hFFE);
    chk("halt_strobes", {ct8, rt8, tt8, wt8}, 4'hF);
    k = 0;
    while (!st10 && k < 300) begin smp(); k++; end
    chk("halt_p10_stops", st10, 1);

    // GOJAM while stopped: no effect
    @(negedge SIM_CLK); GOJAM = 1;
    smp();
    chk("gj_idle_stopped", st8, 1);
    chk("gj_idle_ct", ct8, 1);
    @(negedge SIM_CLK); GOJAM = 0;
    smp();
    chk("gj_idle_tp", tp8, 12'hFFE);

    // MSTP edge coincident with GOJAM is discarded
    @(negedge SIM_CLK); MSTP = 1; GOJAM = 1;
    @(negedge SIM_CLK); GOJAM = 0;
    repeat (4) smp();
    chk("mstp_gj_discard", st8, 1);
    @(negedge SIM_CLK); MSTP = 0;
    smp();

    // Single step, held MSTP
    @(negedge SIM_CLK); MSTP = 1;
    n8 = 0; n10 = 0; e8 = 0;
    for (int i = 0; i < 200; i++) begin
      smp();
      n8 += !st8; n10 += !st10; e8 += end8;
    end
    chk("step1_p8", n8, 96);
    chk("step1_p10", n10, 120);
    chk("step1_ends", e8, 1);
    @(negedge SIM_CLK); MSTP = 0;
    repeat (3) smp();
    @(negedge SIM_CLK); MSTP = 1;
    n8 = 0;
    for (int i = 0; i < 150; i++) begin smp(); n8 += !st8; end
    chk("step2_p8", n8, 96);
    chk("step2_stopped", st8, 1);
    @(negedge SIM_CLK); MSTP = 0;

    // Reset mid-MCT
    @(negedge SIM_CLK); RUN = 1;
    repeat (20) smp();
    @(negedge SIM_CLK); SIM_RST = 1;
    smp();
    chk("rstmid_tp", tp8, 12'hFFE);
    chk("rstmid_strobes", {ct8, rt8, tt8, wt8}, 4'hF);
    chk("rstmid_stopped", st8, 1);
    @(negedge SIM_CLK); RUN = 0;
    @(negedge SIM_CLK); SIM_RST = 0;
    repeat (3) smp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
